// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter sharing one WIDTH-bit register between N requesters.
//   One winner per cycle; the winner's data and a one-cycle load pulse are
//   presented to the shared register, which runs on the same clock.
//
// Ports
//   clk_i       system clock, all state on posedge
//   rst_ni      synchronous active-low reset
//   req_i       [N]       per-requester level-sensitive write request
//   wdata_i     [N*WIDTH] flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt_o       [N]       registered one-hot grant
//   reg_in_o    [WIDTH]   registered data to the register's in pin
//   reg_load_o            registered load pulse, high exactly when gnt_o != 0
//   last_id_o   [IDW]     index of the most recent grant, held between grants
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | no write this cycle, reg_load_o=0, gnt_o=0
// WRITE | one requester is being written, reg_load_o=1, gnt_o one-hot

module reg_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] wdata_i,
  output logic [N-1:0]       gnt_o,
  output logic [WIDTH-1:0]   reg_in_o,
  output logic               reg_load_o,
  output logic [IDW-1:0]     last_id_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0]   reg_in_q, reg_in_d;
  logic [IDW-1:0]     last_id_q, last_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;

  logic [N-1:0]       elig;
  logic               found;
  logic [IDW-1:0]     win;

  // A requester that holds the grant this cycle is excluded so a still-high
  // req cannot produce a second write of the same data at the closing edge.
  always_comb begin : p_search
    int idx;
    idx   = 0;
    elig  = req_i & ~gnt_q;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin : p_next
    state_d   = IDLE;
    gnt_d     = '0;
    reg_in_d  = reg_in_q;
    last_id_d = last_id_q;
    ptr_d     = ptr_q;
    if (found) begin
      state_d   = WRITE;
      gnt_d     = {{(N-1){1'b0}}, 1'b1} << win;
      reg_in_d  = wdata_i[int'(win)*WIDTH +: WIDTH];
      last_id_d = win;
      ptr_d     = (int'(win) == N-1) ? '0 : win + IDW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      reg_in_q  <= '0;
      last_id_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      reg_in_q  <= reg_in_d;
      last_id_q <= last_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign reg_in_o   = reg_in_q;
  assign reg_load_o = (state_q == WRITE);
  assign last_id_o  = last_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter (N=4, WIDTH=16). A behavioural
//   stand-in for the shared register captures reg_in_o when reg_load_o is high.

module tb_reg_write_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 16;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [N-1:0]       req_i;
  logic [N*WIDTH-1:0] wdata_i;
  logic [N-1:0]       gnt_o;
  logic [WIDTH-1:0]   reg_in_o;
  logic               reg_load_o;
  logic [1:0]         last_id_o;

  logic [WIDTH-1:0]   reg_out = '0;

  int vectors     = 0;
  int miscompares = 0;

  reg_write_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .reg_in_o   (reg_in_o),
    .reg_load_o (reg_load_o),
    .last_id_o  (last_id_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (reg_load_o) reg_out <= reg_in_o;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    req_i   = 4'b1111;
    wdata_i = {16'hD004, 16'hC003, 16'hB002, 16'hA001};
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({gnt_o, reg_load_o, reg_in_o, last_id_o} !== {4'b0000, 1'b0, 16'h0000, 2'd0}) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b load=%b in=%h id=%0d exp gnt=0000 load=0 in=0000 id=0",
                 c, gnt_o, reg_load_o, reg_in_o, last_id_o);
      end
    end
    rst_ni = 1'b1;
    tick();
    vectors++;
    if ({gnt_o, reg_load_o, reg_in_o, last_id_o} !== {4'b0001, 1'b1, 16'hA001, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_release got gnt=%b load=%b in=%h id=%0d exp gnt=0001 load=1 in=a001 id=0",
               gnt_o, reg_load_o, reg_in_o, last_id_o);
    end
    req_i = 4'b0000;
    tick();
    vectors++;
    if ({gnt_o, reg_load_o} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_drop got gnt=%b load=%b exp gnt=0000 load=0", gnt_o, reg_load_o);
    end
  endtask

  task automatic test_single();
    wdata_i[2*WIDTH +: WIDTH] = 16'd12345;
    req_i = 4'b0100;
    tick();
    vectors++;
    if ({gnt_o, reg_load_o, reg_in_o, last_id_o} !== {4'b0100, 1'b1, 16'd12345, 2'd2}) begin
      miscompares++;
      $display("FAIL single_grant got gnt=%b load=%b in=%0d id=%0d exp gnt=0100 load=1 in=12345 id=2",
               gnt_o, reg_load_o, reg_in_o, last_id_o);
    end
    req_i = 4'b0000;
    wdata_i[2*WIDTH +: WIDTH] = 16'd999;
    tick();
    vectors++;
    if ({gnt_o, reg_load_o, reg_in_o, last_id_o, reg_out} !== {4'b0000, 1'b0, 16'd12345, 2'd2, 16'd12345}) begin
      miscompares++;
      $display("FAIL single_after got gnt=%b load=%b in=%0d id=%0d out=%0d exp gnt=0000 load=0 in=12345 id=2 out=12345",
               gnt_o, reg_load_o, reg_in_o, last_id_o, reg_out);
    end
    tick();
    vectors++;
    if ({reg_load_o, reg_out} !== {1'b0, 16'd12345}) begin
      miscompares++;
      $display("FAIL single_no_reload got load=%b out=%0d exp load=0 out=12345", reg_load_o, reg_out);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    rst_ni = 1'b0;
    req_i  = 4'b0000;
    tick();
    rst_ni  = 1'b1;
    wdata_i = {16'd4, 16'd3, 16'd2, 16'd1};
    req_i   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if ({gnt_o, reg_load_o, reg_in_o} !== {exp_gnt[k], 1'b1, 16'((k % 4) + 1)}) begin
        miscompares++;
        $display("FAIL rotation_grant k=%0d got gnt=%b load=%b in=%0d exp gnt=%b load=1 in=%0d",
                 k, gnt_o, reg_load_o, reg_in_o, exp_gnt[k], (k % 4) + 1);
      end
      if (k > 0) begin
        vectors++;
        if (reg_out !== 16'(((k - 1) % 4) + 1)) begin
          miscompares++;
          $display("FAIL rotation_out k=%0d got out=%0d exp out=%0d", k, reg_out, ((k - 1) % 4) + 1);
        end
      end
    end
    req_i = 4'b0000;
    tick();
    vectors++;
    if ({gnt_o, reg_load_o, reg_out} !== {4'b0000, 1'b0, 16'd1}) begin
      miscompares++;
      $display("FAIL rotation_end got gnt=%b load=%b out=%0d exp gnt=0000 load=0 out=1", gnt_o, reg_load_o, reg_out);
    end
  endtask

  task automatic test_held();
    wdata_i[0 +: WIDTH] = 16'h8285;  // -32123
    req_i = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ((k % 2) == 0) begin
        if ({gnt_o, reg_load_o, reg_in_o} !== {4'b0001, 1'b1, 16'h8285}) begin
          miscompares++;
          $display("FAIL held_grant k=%0d got gnt=%b load=%b in=%h exp gnt=0001 load=1 in=8285",
                   k, gnt_o, reg_load_o, reg_in_o);
        end
      end else begin
        if ({gnt_o, reg_load_o, reg_out} !== {4'b0000, 1'b0, 16'h8285}) begin
          miscompares++;
          $display("FAIL held_gap k=%0d got gnt=%b load=%b out=%h exp gnt=0000 load=0 out=8285",
                   k, gnt_o, reg_load_o, reg_out);
        end
      end
    end
    req_i = 4'b0000;
    tick();
  endtask

  task automatic test_pointer();
    wdata_i = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_i = 4'b1000;
    tick();
    vectors++;
    if ({gnt_o, last_id_o} !== {4'b1000, 2'd3}) begin
      miscompares++;
      $display("FAIL pointer_g3 got gnt=%b id=%0d exp gnt=1000 id=3", gnt_o, last_id_o);
    end
    req_i = 4'b0000;
    tick();
    req_i = 4'b1010;
    tick();
    vectors++;
    if ({gnt_o, reg_in_o, last_id_o} !== {4'b0010, 16'h1111, 2'd1}) begin
      miscompares++;
      $display("FAIL pointer_first got gnt=%b in=%h id=%0d exp gnt=0010 in=1111 id=1", gnt_o, reg_in_o, last_id_o);
    end
    req_i = 4'b1000;
    tick();
    vectors++;
    if ({gnt_o, reg_in_o, last_id_o, reg_out} !== {4'b1000, 16'h3333, 2'd3, 16'h1111}) begin
      miscompares++;
      $display("FAIL pointer_second got gnt=%b in=%h id=%0d out=%h exp gnt=1000 in=3333 id=3 out=1111",
               gnt_o, reg_in_o, last_id_o, reg_out);
    end
    req_i = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    wdata_i = {16'h0000, 16'h0000, 16'h5555, 16'hAAAA};
    req_i = 4'b0011;
    tick();
    vectors++;
    if (gnt_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL midrst_pre got gnt=%b exp gnt=0001", gnt_o);
    end
    rst_ni = 1'b0;
    tick();
    vectors++;
    if ({gnt_o, reg_load_o, last_id_o, reg_in_o, reg_out} !== {4'b0000, 1'b0, 2'd0, 16'h0000, 16'hAAAA}) begin
      miscompares++;
      $display("FAIL midrst_cancel got gnt=%b load=%b id=%0d in=%h out=%h exp gnt=0000 load=0 id=0 in=0000 out=aaaa",
               gnt_o, reg_load_o, last_id_o, reg_in_o, reg_out);
    end
    rst_ni = 1'b1;
    tick();
    vectors++;
    if ({gnt_o, reg_in_o} !== {4'b0001, 16'hAAAA}) begin
      miscompares++;
      $display("FAIL midrst_release got gnt=%b in=%h exp gnt=0001 in=aaaa", gnt_o, reg_in_o);
    end
    tick();
    vectors++;
    if ({gnt_o, reg_in_o, reg_load_o} !== {4'b0010, 16'h5555, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_next got gnt=%b in=%h load=%b exp gnt=0010 in=5555 load=1", gnt_o, reg_in_o, reg_load_o);
    end
    req_i = 4'b0000;
    tick();
  endtask

  initial begin
    rst_ni  = 1'b0;
    req_i   = '0;
    wdata_i = '0;
    test_reset();
    test_single();
    test_rotation();
    test_held();
    test_pointer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
